// File: rtl/spu_result_pipe.sv
// spu_result_pipe: NUM_PIPES parallel result pipelines of DEPTH stages.
// Each entry carries its result data from issue, a normalised latency tag and
// its destination register. Stage DEPTH drives register-file writeback, and
// every stage is searched for forwarding / hazard detection.
// Optional build macro RESULT_PIPE_PERF_EN adds the perf_stall_cnt and
// perf_wb_cnt counters.
module spu_result_pipe #(
    parameter int NUM_PIPES    = 2,
    parameter int DEPTH        = 7,
    parameter int DATA_W       = 128,
    parameter int ADDR_W       = 7,
    parameter int LAT_W        = 4,
    parameter int NUM_Q        = 3,
    parameter int FLUSH_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PIPES-1:0]        in_valid,
    input  logic [NUM_PIPES-1:0]        in_wr,
    input  logic [NUM_PIPES*ADDR_W-1:0] in_dst,
    input  logic [NUM_PIPES*LAT_W-1:0]  in_lat,
    input  logic [NUM_PIPES*DATA_W-1:0] in_data,
    input  logic                        flush,
    input  logic [NUM_Q*ADDR_W-1:0]     q_addr,
    output logic [NUM_Q-1:0]            q_hit,
    output logic [NUM_Q-1:0]            q_stall,
    output logic [NUM_Q*DATA_W-1:0]     q_data,
    output logic [NUM_PIPES-1:0]        wb_valid,
    output logic [NUM_PIPES*ADDR_W-1:0] wb_addr,
    output logic [NUM_PIPES*DATA_W-1:0] wb_data,
    output logic                        wb_conflict
`ifdef RESULT_PIPE_PERF_EN
    ,
    output logic [31:0]                 perf_stall_cnt,
    output logic [31:0]                 perf_wb_cnt
`endif
);

    // Array index s holds stage s+1; index 0 is the youngest stage.
    logic [NUM_PIPES-1:0] st_vld  [DEPTH];
    logic [NUM_PIPES-1:0] st_wr   [DEPTH];
    logic [ADDR_W-1:0]    st_dst  [DEPTH][NUM_PIPES];
    logic [LAT_W-1:0]     st_lat  [DEPTH][NUM_PIPES];
    logic [DATA_W-1:0]    st_data [DEPTH][NUM_PIPES];

    logic [NUM_PIPES-1:0] wb_raw;
    logic [NUM_Q-1:0]     f_found;
    logic [NUM_Q-1:0]     f_rdy;
    logic [DATA_W-1:0]    f_data [NUM_Q];

    // Latency 0 behaves as 1; anything beyond the pipe depth is ready at the last stage.
    function automatic logic [LAT_W-1:0] norm_lat(input logic [LAT_W-1:0] l);
        if (l == '0) return LAT_W'(1);
        if (32'(l) > DEPTH) return LAT_W'(DEPTH);
        return l;
    endfunction

    // Valid bits: reset beats flush, flush kills the young stages and the same-cycle issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) st_vld[s] <= '0;
        end else begin
            st_vld[0] <= in_valid & {NUM_PIPES{~flush}};
            for (int s = 1; s < DEPTH; s++)
                st_vld[s] <= (flush && s <= FLUSH_STAGES) ? '0 : st_vld[s-1];
        end
    end

    // Payload shifts unconditionally; bubbles carry don't-care contents masked by valid.
    always_ff @(posedge clk) begin
        st_wr[0] <= in_wr;
        for (int p = 0; p < NUM_PIPES; p++) begin
            st_dst[0][p]  <= in_dst[p*ADDR_W +: ADDR_W];
            st_lat[0][p]  <= norm_lat(in_lat[p*LAT_W +: LAT_W]);
            st_data[0][p] <= in_data[p*DATA_W +: DATA_W];
        end
        for (int s = 1; s < DEPTH; s++) begin
            st_wr[s]   <= st_wr[s-1];
            st_dst[s]  <= st_dst[s-1];
            st_lat[s]  <= st_lat[s-1];
            st_data[s] <= st_data[s-1];
        end
    end

    assign wb_raw = st_vld[DEPTH-1] & st_wr[DEPTH-1];

    // Writeback from the last stage; on equal addresses the highest pipe (latest in program order) wins.
    always_comb begin
        wb_valid    = '0;
        wb_addr     = '0;
        wb_data     = '0;
        wb_conflict = 1'b0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            wb_valid[p] = wb_raw[p];
            for (int p2 = p + 1; p2 < NUM_PIPES; p2++) begin
                if (wb_raw[p] && wb_raw[p2] && st_dst[DEPTH-1][p2] == st_dst[DEPTH-1][p]) begin
                    wb_valid[p] = 1'b0;
                    wb_conflict = 1'b1;
                end
            end
            if (wb_valid[p]) begin
                wb_addr[p*ADDR_W +: ADDR_W] = st_dst[DEPTH-1][p];
                wb_data[p*DATA_W +: DATA_W] = st_data[DEPTH-1][p];
            end
        end
    end

    // Forwarding search: scan oldest to youngest, lower pipe first, so the last match is the youngest.
    always_comb begin
        q_hit   = '0;
        q_stall = '0;
        q_data  = '0;
        f_found = '0;
        f_rdy   = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            f_data[q] = '0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int p = 0; p < NUM_PIPES; p++) begin
                    if (st_vld[s][p] && st_wr[s][p] &&
                        st_dst[s][p] == q_addr[q*ADDR_W +: ADDR_W]) begin
                        f_found[q] = 1'b1;
                        f_rdy[q]   = (s + 1) >= int'(st_lat[s][p]);
                        f_data[q]  = st_data[s][p];
                    end
                end
            end
            q_hit[q]   = f_found[q] & f_rdy[q];
            q_stall[q] = f_found[q] & ~f_rdy[q];
            if (q_hit[q]) q_data[q*DATA_W +: DATA_W] = f_data[q];
        end
    end

`ifdef RESULT_PIPE_PERF_EN
    logic [32:0] wb_sum;
    assign wb_sum = {1'b0, perf_wb_cnt} + 33'($countones(wb_valid));

    // Saturating counters for stall cycles and retired register writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_wb_cnt    <= '0;
        end else begin
            if (|q_stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            perf_wb_cnt <= wb_sum[32] ? '1 : wb_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_spu_result_pipe.sv
// Bench for spu_result_pipe: explicit directed sequences, a latency table and
// random traffic, all compared against an in-flight instruction list model.
module tb_spu_result_pipe;
    localparam int NP = 2, D = 7, DW = 128, AW = 7, LW = 4, NQ = 3, F = 2;

    logic clk = 1'b0;
    logic rst, flush;
    logic [NP-1:0]    in_valid, in_wr;
    logic [NP*AW-1:0] in_dst;
    logic [NP*LW-1:0] in_lat;
    logic [NP*DW-1:0] in_data;
    logic [NQ*AW-1:0] q_addr;
    logic [NQ-1:0]    q_hit, q_stall;
    logic [NQ*DW-1:0] q_data;
    logic [NP-1:0]    wb_valid;
    logic [NP*AW-1:0] wb_addr;
    logic [NP*DW-1:0] wb_data;
    logic             wb_conflict;
`ifdef RESULT_PIPE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_wb_cnt;
    longint e_pstall, e_pwb;
`endif

    spu_result_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_wr(in_wr), .in_dst(in_dst),
        .in_lat(in_lat), .in_data(in_data), .flush(flush), .q_addr(q_addr),
        .q_hit(q_hit), .q_stall(q_stall), .q_data(q_data), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_conflict(wb_conflict)
`ifdef RESULT_PIPE_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_wb_cnt(perf_wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // Model: list of in-flight writing instructions with their current stage (age).
    typedef struct {
        int            pipe;
        logic [AW-1:0] dst;
        int            lat;
        logic [DW-1:0] data;
        int            age;
    } ent_t;
    ent_t fl[$];

    logic [NP-1:0]    e_wbv;
    logic [NP*AW-1:0] e_wba;
    logic [NP*DW-1:0] e_wbd;
    logic             e_conf;
    logic [NQ-1:0]    e_hit, e_stall;
    logic [NQ*DW-1:0] e_qd;

    typedef struct { logic [LW-1:0] lat; int first_rdy; } lat_vec_t;
    lat_vec_t lv [6];

    task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compute_exp();
        logic [NP-1:0] rv;
        logic [AW-1:0] ra [NP];
        logic [DW-1:0] rd [NP];
        logic keep;
        e_wbv = '0; e_wba = '0; e_wbd = '0; e_conf = 1'b0;
        e_hit = '0; e_stall = '0; e_qd = '0; rv = '0;
        for (int p = 0; p < NP; p++) begin ra[p] = '0; rd[p] = '0; end
        for (int i = 0; i < fl.size(); i++)
            if (fl[i].age == D) begin
                rv[fl[i].pipe] = 1'b1;
                ra[fl[i].pipe] = fl[i].dst;
                rd[fl[i].pipe] = fl[i].data;
            end
        for (int p = 0; p < NP; p++) begin
            keep = rv[p];
            for (int p2 = p + 1; p2 < NP; p2++)
                if (rv[p] && rv[p2] && ra[p2] == ra[p]) begin keep = 1'b0; e_conf = 1'b1; end
            e_wbv[p] = keep;
            if (keep) begin e_wba[p*AW +: AW] = ra[p]; e_wbd[p*DW +: DW] = rd[p]; end
        end
        for (int q = 0; q < NQ; q++) begin
            int best;
            best = -1;
            for (int i = 0; i < fl.size(); i++)
                if (fl[i].dst == q_addr[q*AW +: AW])
                    if (best < 0 || fl[i].age < fl[best].age ||
                        (fl[i].age == fl[best].age && fl[i].pipe > fl[best].pipe)) best = i;
            if (best >= 0) begin
                if (fl[best].age >= fl[best].lat) begin
                    e_hit[q] = 1'b1;
                    e_qd[q*DW +: DW] = fl[best].data;
                end else e_stall[q] = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        compute_exp();
        chk("wb_valid", 384'(wb_valid), 384'(e_wbv));
        chk("wb_addr", 384'(wb_addr), 384'(e_wba));
        chk("wb_data", 384'(wb_data), 384'(e_wbd));
        chk("wb_conflict", 384'(wb_conflict), 384'(e_conf));
        chk("q_hit", 384'(q_hit), 384'(e_hit));
        chk("q_stall", 384'(q_stall), 384'(e_stall));
        chk("q_data", q_data, e_qd);
`ifdef RESULT_PIPE_PERF_EN
        chk("perf_stall_cnt", 384'(perf_stall_cnt), 384'(e_pstall));
        chk("perf_wb_cnt", 384'(perf_wb_cnt), 384'(e_pwb));
`endif
    endtask

    // Advance the model across one clock edge using the inputs held for this cycle.
    task automatic model_update();
        ent_t nl[$];
        ent_t e;
`ifdef RESULT_PIPE_PERF_EN
        if (rst) begin e_pstall = 0; e_pwb = 0; end
        else begin
            if (|e_stall && e_pstall < 64'hFFFF_FFFF) e_pstall++;
            e_pwb = e_pwb + $countones(e_wbv);
            if (e_pwb > 64'hFFFF_FFFF) e_pwb = 64'hFFFF_FFFF;
        end
`endif
        if (rst) begin fl.delete(); return; end
        foreach (fl[i]) begin
            e = fl[i];
            if (flush && e.age <= F) continue;
            e.age++;
            if (e.age <= D) nl.push_back(e);
        end
        if (!flush)
            for (int p = 0; p < NP; p++)
                if (in_valid[p] && in_wr[p]) begin
                    int l;
                    l = int'(in_lat[p*LW +: LW]);
                    e.pipe = p;
                    e.dst  = in_dst[p*AW +: AW];
                    e.lat  = (l == 0) ? 1 : ((l > D) ? D : l);
                    e.data = in_data[p*DW +: DW];
                    e.age  = 1;
                    nl.push_back(e);
                end
        fl = nl;
    endtask

    task automatic settle(); #1; endtask

    task automatic tick();
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_in();
        in_valid = '0; in_wr = '0; flush = 1'b0;
    endtask

    task automatic issue(input int p, input logic [AW-1:0] dst, input logic [LW-1:0] lat,
                         input logic [DW-1:0] data);
        in_valid[p] = 1'b1;
        in_wr[p]    = 1'b1;
        in_dst[p*AW +: AW]  = dst;
        in_lat[p*LW +: LW]  = lat;
        in_data[p*DW +: DW] = data;
    endtask

    task automatic hard_reset();
        clear_in();
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0;
    endtask

    int cnt0, cnt1;

    initial begin
        lv[0] = '{4'd0, 1};  lv[1] = '{4'd1, 1};  lv[2] = '{4'd3, 3};
        lv[3] = '{4'd7, 7};  lv[4] = '{4'd8, 7};  lv[5] = '{4'd15, 7};

        in_dst = '0; in_lat = '0; in_data = '0; q_addr = '0;
        clear_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        fl.delete();
`ifdef RESULT_PIPE_PERF_EN
        e_pstall = 0; e_pwb = 0;
`endif
        #1;
        rst = 1'b0;
        settle();
        chk("rst_wb_valid", 384'(wb_valid), 384'(0));
        chk("rst_wb_conflict", 384'(wb_conflict), 384'(0));
        chk("rst_q_hit", 384'(q_hit), 384'(0));
        chk("rst_q_stall", 384'(q_stall), 384'(0));
        chk("rst_wb_addr_data", 384'({wb_addr, wb_data}), 384'(0));

        // Sequence 1: single lat=3 result, forwarded then written back after 7 cycles.
        issue(0, 7'd5, 4'd3, {32{4'hA}});
        q_addr = '0; q_addr[0 +: AW] = 7'd5;
        settle(); tick(); clear_in();
        for (int k = 1; k <= 8; k++) begin
            settle();
            chk($sformatf("s1_stall_k%0d", k), 384'(q_stall[0]), 384'(k < 3));
            chk($sformatf("s1_hit_k%0d", k), 384'(q_hit[0]), 384'(k >= 3 && k <= 7));
            if (k >= 3 && k <= 7) chk($sformatf("s1_data_k%0d", k), 384'(q_data[DW-1:0]), 384'({32{4'hA}}));
            chk($sformatf("s1_wbv_k%0d", k), 384'(wb_valid), 384'(k == 7 ? 2'b01 : 2'b00));
            if (k == 7) chk("s1_wb_addr", 384'(wb_addr[AW-1:0]), 384'(5));
            tick();
        end

        // Sequence 2: same-cycle same-destination issue on both pipes.
        issue(0, 7'd9, 4'd1, 128'h11);
        issue(1, 7'd9, 4'd1, 128'h22);
        q_addr[0 +: AW] = 7'd9;
        settle(); tick(); clear_in();
        for (int k = 1; k <= 7; k++) begin
            settle();
            chk($sformatf("s2_data_k%0d", k), 384'({q_hit[0], q_data[DW-1:0]}), 384'({1'b1, 128'h22}));
            if (k == 7) begin
                chk("s2_wbv", 384'(wb_valid), 384'(2'b10));
                chk("s2_conflict", 384'(wb_conflict), 384'(1));
                chk("s2_wb1", 384'({wb_addr[AW +: AW], wb_data[DW +: DW]}), 384'({7'd9, 128'h22}));
            end
            tick();
        end

        // Sequence 3: a younger not-ready match hides an older ready one.
        issue(0, 7'd4, 4'd7, 128'h1);
        q_addr[0 +: AW] = 7'd4;
        settle(); tick(); clear_in();
        issue(0, 7'd4, 4'd7, 128'h2);
        settle(); tick(); clear_in();
        for (int k = 1; k <= 7; k++) begin
            settle();
            chk($sformatf("s3_stall_k%0d", k), 384'({q_hit[0], q_stall[0]}), 384'(k < 7 ? 2'b01 : 2'b10));
            if (k == 7) chk("s3_data", 384'(q_data[DW-1:0]), 384'(128'h2));
            tick();
        end
        repeat (2) begin settle(); tick(); end

        // Sequence 4: fill every stage, then flush while also issuing.
        for (int i = 0; i < D; i++) begin
            issue(0, 7'(2 * i), 4'(1 + i % 7), 128'(100 + i));
            issue(1, 7'(2 * i + 1), 4'(1 + i % 5), 128'(200 + i));
            q_addr[AW +: AW] = 7'(2 * i);
            settle(); tick();
        end
        issue(0, 7'd100, 4'd1, 128'hDEAD);
        issue(1, 7'd101, 4'd1, 128'hBEEF);
        flush = 1'b1;
        q_addr[0 +: AW] = 7'd12; q_addr[AW +: AW] = 7'd100; q_addr[2*AW +: AW] = 7'd13;
        cnt0 = 0; cnt1 = 0;
        settle();
        cnt0 += int'(wb_valid[0]); cnt1 += int'(wb_valid[1]);
        tick(); clear_in();
        for (int k = 0; k < 9; k++) begin
            settle();
            cnt0 += int'(wb_valid[0]); cnt1 += int'(wb_valid[1]);
            if (k == 0) chk("s4_flushed_q", 384'({q_hit, q_stall}), 384'(0));
            tick();
        end
        chk("s4_wb_cnt_p0", 384'(cnt0), 384'(D - F));
        chk("s4_wb_cnt_p1", 384'(cnt1), 384'(D - F));

        // Sequence 5: reset with three results in flight.
        for (int i = 0; i < 3; i++) begin
            issue(0, 7'(40 + i), 4'd1, 128'(300 + i));
            settle(); tick();
        end
        clear_in();
        rst = 1'b1;
        settle(); tick();
        rst = 1'b0;
        q_addr[0 +: AW] = 7'd40; q_addr[AW +: AW] = 7'd41; q_addr[2*AW +: AW] = 7'd42;
        for (int k = 0; k < 9; k++) begin
            settle();
            chk($sformatf("s5_quiet_k%0d", k),
                384'({wb_valid, q_hit, q_stall, q_data}), 384'(0));
            tick();
        end

        // Latency normalisation table.
        for (int v = 0; v < 6; v++) begin
            hard_reset();
            issue(1, 7'd33, lv[v].lat, 128'(v + 1));
            q_addr[0 +: AW] = 7'd33;
            settle(); tick(); clear_in();
            for (int k = 1; k <= D; k++) begin
                settle();
                chk($sformatf("lat%0d_k%0d", lv[v].lat, k), 384'({q_hit[0], q_stall[0]}),
                    384'(k >= lv[v].first_rdy ? 2'b10 : 2'b01));
                tick();
            end
        end

        // Random traffic against the model.
        hard_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid = 2'($urandom);
            in_wr    = 2'($urandom);
            for (int p = 0; p < NP; p++) begin
                in_dst[p*AW +: AW]  = 7'($urandom_range(0, 7));
                in_lat[p*LW +: LW]  = 4'($urandom);
                in_data[p*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
            end
            for (int q = 0; q < NQ; q++) q_addr[q*AW +: AW] = 7'($urandom_range(0, 7));
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            settle(); tick();
        end
        rst = 1'b0;
        clear_in();
        repeat (D + 1) begin settle(); tick(); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spu_result_pipe.md
Name: spu_result_pipe

Overview:
- Parametrised successor to the fixed two-pipe, seven-stage even/odd staging wrapper.
- Models NUM_PIPES in-flight result pipelines of configurable DEPTH, with per-instruction latency tagging.
- Provides register-file writeback at the final stage and a forwarding/hazard lookup across all stages.
- Sits between the issue/operand-fetch stage and the 128x128 register file of the SPU datapath.

Parameters:
- NUM_PIPES, 2, number of parallel issue pipes (pipe 0 = even, pipe 1 = odd).
- DEPTH, 7, stages per pipe, minimum 2.
- DATA_W, 128, result width.
- ADDR_W, 7, register address width.
- LAT_W, 4, latency field width.
- NUM_Q, 3, forwarding query ports.
- FLUSH_STAGES, 2, number of youngest stages killed by flush.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  NUM_PIPES  issue valid, one bit per pipe.
- in_wr  in  NUM_PIPES  instruction writes a register.
- in_dst  in  NUM_PIPES*ADDR_W  destination register.
- in_lat  in  NUM_PIPES*LAT_W  result latency in cycles.
- in_data  in  NUM_PIPES*DATA_W  result value, supplied at issue.
- flush  in  1  kill young entries.
- q_addr  in  NUM_Q*ADDR_W  forwarding query addresses.
- q_hit  out  NUM_Q  ready matching result found.
- q_stall  out  NUM_Q  youngest match exists but is not yet ready.
- q_data  out  NUM_Q*DATA_W  forwarded value.
- wb_valid  out  NUM_PIPES  register-file write enable.
- wb_addr  out  NUM_PIPES*ADDR_W  write address.
- wb_data  out  NUM_PIPES*DATA_W  write data.
- wb_conflict  out  1  two or more pipes wrote the same address this cycle.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all stage valid bits cleared. wb_valid=0, wb_conflict=0, q_hit=0, q_stall=0. Address and data outputs 0.
- Stage entry: each entry holds {valid, wr, dst, lat, data, age}, where age is the stage number 1..DEPTH.
- Issue: an issue on cycle N occupies stage 1 at edge N+1 and advances one stage per cycle. There is no back-pressure.
- Stage DEPTH is presented combinationally on wb_*.
- Writeback: wb_valid[p] = valid & wr of pipe p's stage DEPTH. Total issue-to-writeback latency is DEPTH cycles.
- Latency normalisation at issue: lat=0 is treated as 1; lat>DEPTH is clamped to DEPTH.
- Readiness: an entry at stage s is ready when s >= lat.
- Forwarding, per query q, evaluated combinationally over all valid, wr=1 entries with dst==q_addr:
  - Youngest wins: lowest stage number.
  - Tie at the same stage: the higher pipe index wins (program order is even then odd).
  - If the youngest match is ready: q_hit=1, q_stall=0, q_data=its data.
  - If the youngest match is not ready: q_hit=0, q_stall=1, q_data=0. An older ready match is never used.
  - No match: q_hit=0, q_stall=0, q_data=0.
- Writeback conflict: if two or more pipes have wb_valid with equal wb_addr, the highest pipe index keeps wb_valid=1 and lower pipes are forced to 0. wb_conflict=1 that cycle.
- Flush:
  - At the clock edge, clears the valid bits of stages 1..FLUSH_STAGES in all pipes.
  - Also drops any in_valid issued in the same cycle, so that issue never enters.
  - Stages beyond FLUSH_STAGES continue and write back normally.
- Reset mid-flight: all in-flight entries are discarded and no writeback occurs from them. Reset has priority over flush and issue.
- An invalid issue slot inserts a bubble (valid=0). Contents of a bubble are don't-care, but its outputs must read 0.

Optional Feature:
- Macro RESULT_PIPE_PERF_EN.
- When defined, two outputs are added:
  - perf_stall_cnt (32-bit): counts cycles in which any q_stall=1.
  - perf_wb_cnt (32-bit): counts asserted wb_valid bits, adding up to NUM_PIPES per cycle.
  - Both counters saturate at all-ones and clear on rst.
- When undefined, these ports and their counters are absent. Functional behaviour is identical otherwise.

Test Plan:
- Default params; issue pipe0 dst=5, lat=3, data=0xA..A; q_addr0=5.
  - Expect q_stall=1 at stages 1-2, q_hit=1 with data 0xA..A at stages 3-7.
  - Expect wb_valid[0]=1, addr 5, exactly 7 cycles after issue.
- Same-cycle issue of pipe0 and pipe1, both dst=9, lat=1, data 0x11 and 0x22.
  - Expect q_data=0x22.
  - At writeback, expect wb_valid=2'b10 and wb_conflict=1.
- Issue dst=4 lat=7 (data 0x1), then next cycle dst=4 lat=7 (data 0x2).
  - Expect q_stall=1 and not a hit on the older entry, until the younger entry reaches stage 7.
- Fill all stages with wr=1, then assert flush for 1 cycle.
  - Expect exactly DEPTH-FLUSH_STAGES=5 writebacks per pipe to follow, and none for the flushed entries.
- Assert rst at cycle 3 after three issues.
  - Expect no wb_valid afterwards and all q outputs 0.
- lat=0 and lat=15 issues.
  - Expect ready from stage 1 and from stage 7 respectively.
  - With RESULT_PIPE_PERF_EN, perf_wb_cnt=2 after both write back.
